hazard_scoreboard_unit: RTL and testbench

- Parametrised successor to the single-cycle load-use interlock: a per-register countdown scoreboard in the ID stage of the 5-stage RISC-V pipeline.
- Handles load-use hazards, multi-cycle MDU results, WAW ordering, a single-MDU structural hazard, and EX-stage branch flush.
- Drives the PC/IF-ID write enables, ID/EX bubble insertion and IF/ID flush.

---
 rtl/hazard_pkg.sv | 27 ++
 rtl/reg_countdown.sv | 33 +++
 rtl/hazard_scoreboard_unit.sv | 144 ++++++++++++++
 tb/tb_hazard_scoreboard_unit.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// ---------------------------------------------------------------------------
// hazard_pkg
// Shared definitions for the ID-stage hazard scoreboard:
//   lat_class_t   - latency class carried by each decoded instruction
//   DEF_LOAD_LAT  - default cycles a load result is hidden from ID
//   DEF_MDU_LAT   - default mul/div result latency
//   calc_cnt_w()  - width of a countdown counter able to hold the
//                   largest latency
// ---------------------------------------------------------------------------
package hazard_pkg;

  typedef enum logic [1:0] {
    LAT_ALU  = 2'd0,
    LAT_LOAD = 2'd1,
    LAT_MDU  = 2'd2
  } lat_class_t;

  localparam int DEF_LOAD_LAT = 1;
  localparam int DEF_MDU_LAT  = 4;

  function automatic int calc_cnt_w(input int load_lat, input int mdu_lat);
    int max_lat;
    max_lat = (load_lat > mdu_lat) ? load_lat : mdu_lat;
    return $clog2(max_lat + 1);
  endfunction

endpackage

// File: rtl/reg_countdown.sv
// ---------------------------------------------------------------------------
// reg_countdown
// Saturating down-counter with a load override. Each cycle the count drops
// by one until it reaches zero; load_en replaces that cycle's decrement with
// load_val.
// Ports:
//   clk       pipeline clock
//   reset     asynchronous, active-high; clears count
//   load_en   load load_val this cycle instead of decrementing
//   load_val  new count value
//   count     current count
// ---------------------------------------------------------------------------
module reg_countdown #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_en,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load_en) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard_unit
// Per-register countdown scoreboard for the ID stage of the 5-stage RISC-V
// pipeline. cnt[r] holds how many more cycles a dependent ID instruction
// must wait before forwarding can supply register r. Detects RAW (load-use,
// MDU), WAW ordering, the single-MDU structural hazard, and applies the
// EX-stage branch flush, which wins over any stall.
//
// Optional build macro HAZARD_STALL_PERF_EN adds stall_cycles/flush_count
// performance counters; without it those ports do not exist.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   id_valid              ID holds a valid instruction
//   id_rs1/id_rs2         source indices, id_rs1_used/id_rs2_used qualify them
//   id_rd, id_reg_write   destination index and write enable
//   id_lat_class          0 ALU, 1 LOAD, 2 MDU, 3 reserved (treated as ALU)
//   ex_branch_taken       taken branch/jump resolved in EX this cycle
//   stall                 ID instruction held this cycle
//   pc_write_en           PC may update
//   if_id_write_en        IF/ID may load
//   id_ex_bubble          load a NOP into ID/EX
//   if_id_flush           clear IF/ID
//   stall_cycles          (perf build) cycles with stall=1, wraps
//   flush_count           (perf build) cycles with ex_branch_taken=1, wraps
// ---------------------------------------------------------------------------
module hazard_scoreboard_unit
  import hazard_pkg::*;
#(
  parameter int NUM_REGS   = 32,
  parameter int REG_ADDR_W = 5,
  parameter int LOAD_LAT   = DEF_LOAD_LAT,
  parameter int MDU_LAT    = DEF_MDU_LAT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic [1:0]            id_lat_class,
  input  logic                  ex_branch_taken,
  output logic                  stall,
  output logic                  pc_write_en,
  output logic                  if_id_write_en,
  output logic                  id_ex_bubble,
  output logic                  if_id_flush
`ifdef HAZARD_STALL_PERF_EN
  ,
  output logic [31:0]           stall_cycles,
  output logic [31:0]           flush_count
`endif
);

  localparam int CNT_W = calc_cnt_w(LOAD_LAT, MDU_LAT);

  // Result latency of each class; reserved class 3 behaves as ALU.
  function automatic logic [CNT_W-1:0] lat_of(input logic [1:0] cls);
    case (cls)
      LAT_LOAD: return CNT_W'(LOAD_LAT);
      LAT_MDU:  return CNT_W'(MDU_LAT);
      default:  return '0;
    endcase
  endfunction

  logic [CNT_W-1:0] cnt [NUM_REGS];
  logic [CNT_W-1:0] mdu_busy;
  logic [CNT_W-1:0] dest_lat;
  logic             raw1, raw2, waw, struct_hz, hz;
  logic             issue, rd_load_en, mdu_load_en;

  assign dest_lat = lat_of(id_lat_class);

  // x0 is hard-wired and never tracked.
  assign cnt[0] = '0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg_cnt
    reg_countdown #(.W(CNT_W)) u_cnt (
      .clk      (clk),
      .reset    (reset),
      .load_en  (rd_load_en && (id_rd == REG_ADDR_W'(r))),
      .load_val (dest_lat),
      .count    (cnt[r])
    );
  end

  reg_countdown #(.W(CNT_W)) u_mdu_busy (
    .clk      (clk),
    .reset    (reset),
    .load_en  (mdu_load_en),
    .load_val (CNT_W'(MDU_LAT)),
    .count    (mdu_busy)
  );

  always_comb begin
    raw1 = id_valid && id_rs1_used && (id_rs1 != '0) && (cnt[id_rs1] != '0);
    raw2 = id_valid && id_rs2_used && (id_rs2 != '0) && (cnt[id_rs2] != '0);
    // A younger write may not land before an older, slower one to the same rd.
    waw  = id_valid && id_reg_write && (id_rd != '0) && (cnt[id_rd] > dest_lat);
    struct_hz = id_valid && (id_lat_class == LAT_MDU) && (mdu_busy != '0);
    hz   = raw1 || raw2 || waw || struct_hz;
  end

  // A killed (flushed) instruction never claims a scoreboard entry.
  assign issue       = id_valid && !hz && !ex_branch_taken;
  assign rd_load_en  = issue && id_reg_write && (id_rd != '0);
  assign mdu_load_en = issue && (id_lat_class == LAT_MDU);

  // Flush beats stall: the ID instruction is dead, so holding it is pointless.
  always_comb begin
    stall          = 1'b0;
    pc_write_en    = 1'b1;
    if_id_write_en = 1'b1;
    id_ex_bubble   = 1'b0;
    if_id_flush    = 1'b0;
    if (!reset) begin
      if (ex_branch_taken) begin
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
      end else if (hz) begin
        stall          = 1'b1;
        pc_write_en    = 1'b0;
        if_id_write_en = 1'b0;
        id_ex_bubble   = 1'b1;
      end
    end
  end

`ifdef HAZARD_STALL_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (stall)           stall_cycles <= stall_cycles + 32'd1;
      if (ex_branch_taken) flush_count  <= flush_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// ---------------------------------------------------------------------------
// tb_hazard_scoreboard_unit
// Directed vector table for the hazard scenarios, a hand-written reset
// sequence, then randomized traffic checked against a timestamp model: each
// register remembers the cycle at which its value becomes forwardable.
// Output vector order: {stall, pc_write_en, if_id_write_en, id_ex_bubble,
// if_id_flush}.
// ---------------------------------------------------------------------------
module tb_hazard_scoreboard_unit;

  localparam int LOAD_LAT = 1;
  localparam int MDU_LAT  = 4;

  localparam logic [1:0] C_ALU = 2'd0;
  localparam logic [1:0] C_LD  = 2'd1;
  localparam logic [1:0] C_MDU = 2'd2;

  localparam logic [4:0] O_DEF = 5'b01100;
  localparam logic [4:0] O_STL = 5'b10010;
  localparam logic [4:0] O_FLS = 5'b01111;

  logic       clk, reset;
  logic       id_valid, id_rs1_used, id_rs2_used, id_reg_write, ex_branch_taken;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic [1:0] id_lat_class;
  logic       stall, pc_write_en, if_id_write_en, id_ex_bubble, if_id_flush;
`ifdef HAZARD_STALL_PERF_EN
  logic [31:0] stall_cycles, flush_count;
  int          exp_stall_cycles, exp_flush_count;
`endif

  hazard_scoreboard_unit #(
    .NUM_REGS(32), .REG_ADDR_W(5), .LOAD_LAT(LOAD_LAT), .MDU_LAT(MDU_LAT)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .id_valid        (id_valid),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_rs1_used     (id_rs1_used),
    .id_rs2_used     (id_rs2_used),
    .id_rd           (id_rd),
    .id_reg_write    (id_reg_write),
    .id_lat_class    (id_lat_class),
    .ex_branch_taken (ex_branch_taken),
    .stall           (stall),
    .pc_write_en     (pc_write_en),
    .if_id_write_en  (if_id_write_en),
    .id_ex_bubble    (id_ex_bubble),
    .if_id_flush     (if_id_flush)
`ifdef HAZARD_STALL_PERF_EN
    ,
    .stall_cycles    (stall_cycles),
    .flush_count     (flush_count)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- types ----------------
  typedef struct {
    logic       valid;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] rd;
    logic       rw;
    logic [1:0] cls;
    logic       br;
  } op_t;

  typedef struct {
    op_t        op;
    logic [4:0] exp;
    string      name;
  } vec_t;

  vec_t       tbl[$];
  logic [4:0] exp_q[$];
  int         checks   = 0;
  int         failures = 0;

  // ---------------- reference model ----------------
  // ready_at[r]: first cycle number at which a reader of r no longer waits.
  int now = 0;
  int ready_at[32];
  int mdu_free_at = 0;

  function automatic int lat_of(input logic [1:0] c);
    if (c == C_LD)  return LOAD_LAT;
    if (c == C_MDU) return MDU_LAT;
    return 0;
  endfunction

  function automatic int wait_left(input logic [4:0] r);
    if (r == 5'd0) return 0;
    return (ready_at[r] > now) ? ready_at[r] - now : 0;
  endfunction

  function automatic logic model_hz(input op_t o);
    logic h;
    h = 1'b0;
    if (o.valid) begin
      if (o.u1 && wait_left(o.rs1) > 0) h = 1'b1;
      if (o.u2 && wait_left(o.rs2) > 0) h = 1'b1;
      if (o.rw && wait_left(o.rd) > lat_of(o.cls)) h = 1'b1;
      if (o.cls == C_MDU && mdu_free_at > now) h = 1'b1;
    end
    return h;
  endfunction

  function automatic logic [4:0] model_out(input op_t o);
    if (o.br) return O_FLS;
    if (model_hz(o)) return O_STL;
    return O_DEF;
  endfunction

  function automatic void model_advance(input op_t o, input logic rst);
    logic iss;
    iss = o.valid && !model_hz(o) && !o.br;
    if (rst) begin
      foreach (ready_at[r]) ready_at[r] = 0;
      mdu_free_at = 0;
    end else if (iss) begin
      if (o.rw && o.rd != 5'd0) ready_at[o.rd] = now + 1 + lat_of(o.cls);
      if (o.cls == C_MDU) mdu_free_at = now + 1 + MDU_LAT;
    end
    now++;
  endfunction

  // ---------------- stimulus helpers ----------------
  function automatic op_t mk(input logic v, input logic [4:0] rs1, input logic u1,
                             input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                             input logic rw, input logic [1:0] cls, input logic br);
    op_t o;
    o.valid = v; o.rs1 = rs1; o.u1 = u1; o.rs2 = rs2; o.u2 = u2;
    o.rd = rd; o.rw = rw; o.cls = cls; o.br = br;
    return o;
  endfunction

  function automatic op_t op_ld(input logic [4:0] rd);
    return mk(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, rd, 1'b1, C_LD, 1'b0);
  endfunction
  function automatic op_t op_mul(input logic [4:0] rd);
    return mk(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, rd, 1'b1, C_MDU, 1'b0);
  endfunction
  function automatic op_t op_use(input logic [4:0] rs);
    return mk(1'b1, rs, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, C_ALU, 1'b0);
  endfunction
  function automatic op_t op_nop();
    return mk(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, C_ALU, 1'b0);
  endfunction

  function automatic void add_vec(input op_t o, input logic [4:0] e, input string n);
    vec_t v;
    v.op = o; v.exp = e; v.name = n;
    tbl.push_back(v);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input op_t o);
    id_valid        = o.valid;
    id_rs1          = o.rs1;
    id_rs1_used     = o.u1;
    id_rs2          = o.rs2;
    id_rs2_used     = o.u2;
    id_rd           = o.rd;
    id_reg_write    = o.rw;
    id_lat_class    = o.cls;
    ex_branch_taken = o.br;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check_outputs(input string name);
    logic [4:0] got, e;
    got = {stall, pc_write_en, if_id_write_en, id_ex_bubble, if_id_flush};
    e = exp_q.pop_front();
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL %s: got=%b expected=%b (stall,pc_we,ifid_we,bubble,flush) t=%0t",
               name, got, e, $time);
    end
  endtask

  // One normal cycle: entered and left at posedge+1.
  task automatic step(input op_t o, input logic [4:0] e, input string name);
    drive(o);
    exp_q.push_back(e);
    #2;
    check_outputs(name);
`ifdef HAZARD_STALL_PERF_EN
    if (e[4]) exp_stall_cycles++;
    if (o.br) exp_flush_count++;
`endif
    @(posedge clk);
    model_advance(o, 1'b0);
    #1;
  endtask

  // One cycle with reset asserted mid-cycle; outputs must be defaults.
  task automatic step_reset(input op_t o, input string name);
    drive(o);
    reset = 1'b1;
    exp_q.push_back(O_DEF);
    #2;
    check_outputs(name);
`ifdef HAZARD_STALL_PERF_EN
    exp_stall_cycles = 0;
    exp_flush_count  = 0;
`endif
    @(posedge clk);
    model_advance(o, 1'b1);
    #1;
    reset = 1'b0;
  endtask

  // ---------------- test ----------------
  initial begin
    // Load-use
    add_vec(op_ld(5'd5),  O_DEF, "lu_load_x5");
    add_vec(op_use(5'd5), O_STL, "lu_stall_1");
    add_vec(op_use(5'd5), O_DEF, "lu_issue_2nd");
    // MDU chain
    add_vec(op_mul(5'd7), O_DEF, "mdu_issue_mul_x7");
    for (int i = 0; i < 4; i++) add_vec(op_use(5'd7), O_STL, $sformatf("mdu_stall_%0d", i));
    add_vec(op_use(5'd7), O_DEF, "mdu_consumer_issue");
    // x0 and unused sources
    add_vec(op_ld(5'd0), O_DEF, "x0_load");
    add_vec(mk(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd6, 1'b1, C_ALU, 1'b0), O_DEF, "x0_reader");
    add_vec(op_ld(5'd3), O_DEF, "unused_load_x3");
    add_vec(mk(1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, C_ALU, 1'b0), O_DEF, "unused_rs1");
    // WAW: load behind mul to x9 waits until the mul has at most 1 cycle left
    add_vec(op_mul(5'd9), O_DEF, "waw_mul_x9");
    for (int i = 0; i < 3; i++)
      add_vec(mk(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, C_LD, 1'b0), O_STL,
              $sformatf("waw_stall_%0d", i));
    add_vec(mk(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, C_LD, 1'b0), O_DEF, "waw_load_issue");
    add_vec(op_nop(), O_DEF, "idle_nop");
    // Structural: back-to-back mul
    add_vec(op_mul(5'd10), O_DEF, "struct_mul1");
    for (int i = 0; i < 4; i++) add_vec(op_mul(5'd11), O_STL, $sformatf("struct_stall_%0d", i));
    add_vec(op_mul(5'd11), O_DEF, "struct_mul2_issue");
    for (int i = 0; i < 4; i++) add_vec(op_nop(), O_DEF, "drain_nop");
    // Flush during a load-use hazard; the killed load to x12 claims nothing
    add_vec(op_ld(5'd5), O_DEF, "fl_load_x5");
    add_vec(mk(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd12, 1'b1, C_LD, 1'b1), O_FLS, "fl_flush_wins");
    add_vec(op_use(5'd12), O_DEF, "fl_no_entry_x12");
    add_vec(mk(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, C_ALU, 1'b1), O_FLS, "fl_invalid_id");

    // Reset at time zero
    reset = 1'b1;
    drive(mk(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, C_MDU, 1'b1));
    exp_q.push_back(O_DEF);
    #3;
    check_outputs("reset_outputs");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    foreach (tbl[i]) step(tbl[i].op, tbl[i].exp, tbl[i].name);

    // Reset two cycles after a mul to x4 issues
    step(op_mul(5'd4), O_DEF, "rst_mul_x4");
    step(op_use(5'd4), O_STL, "rst_reader_stall_a");
    step(op_use(5'd4), O_STL, "rst_reader_stall_b");
    step_reset(mk(1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, C_MDU, 1'b1), "rst_in_reset");
    step(op_use(5'd4), O_DEF, "rst_reader_after");
    step(op_mul(5'd4), O_DEF, "rst_mdu_free_after");

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      op_t o;
      o = mk($urandom_range(0, 9) != 0, 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
             1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom_range(0, 15) == 0);
      if ($urandom_range(0, 99) == 0) step_reset(o, "rand_reset");
      else step(o, model_out(o), "rand");
    end

`ifdef HAZARD_STALL_PERF_EN
    checks++;
    if (stall_cycles !== 32'(exp_stall_cycles)) begin
      failures++;
      $display("FAIL perf_stall_cycles: got=%0d expected=%0d", stall_cycles, exp_stall_cycles);
    end
    checks++;
    if (flush_count !== 32'(exp_flush_count)) begin
      failures++;
      $display("FAIL perf_flush_count: got=%0d expected=%0d", flush_count, exp_flush_count);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
